keypad_responder: RTL

Behavioural keypad responder: the passive end of the 4x4 matrix-keypad row/column interface. The scanner drives one-hot `row` and samples `col`. This block takes 8-bit key codes (`{row, col}`, same format the scanner produces), queues them, and presses each one for a programmed time. While a key is pressed, `col` answers the scanner's row drive exactly like a physical key. It replaces the physical keypad on the FPGA board for self-test and serves as the keypad model in scanner simulations.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/keypad_code_fifo.sv | 68 ++++++
 rtl/keypad_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad: FSM encoding, key-code field
// positions and a one-hot check that the scanner side can reuse.
package keypad_pkg;

   typedef enum logic [1:0] {
      KP_IDLE  = 2'd0,
      KP_PRESS = 2'd1,
      KP_GAP   = 2'd2
   } kp_state_e;

   localparam int ROW_MSB = 7;
   localparam int ROW_LSB = 4;
   localparam int COL_MSB = 3;
   localparam int COL_LSB = 0;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// Small synchronous FIFO for 8-bit key codes; exposes full/empty and the
// current fill level so the owner can precompute its registered busy flag.
module keypad_code_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [7:0]                 wdata,
   input  logic                       pop,
   output logic [7:0]                 rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   import keypad_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // Pointer and fill-level next-state; push is never issued while full.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/keypad_responder.sv
// Passive keypad model: queues validated key codes and presses each for a
// fixed time, answering the scanner's row drive on col like a real key.
module keypad_responder #(
   parameter int HOLD_CYCLES = 4000000,
   parameter int GAP_CYCLES  = 4000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic       key_ready,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_active,
   output logic       busy,
   output logic       code_err
);
   import keypad_pkg::*;

   localparam logic [1:0] S_IDLE  = KP_IDLE;
   localparam logic [1:0] S_PRESS = KP_PRESS;
   localparam logic [1:0] S_GAP   = KP_GAP;

   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int FAW     = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cur_row_q, cur_row_d;
   logic [3:0]    cur_col_q, cur_col_d;
   logic          key_active_q, key_active_d;
   logic          busy_q, busy_d;
   logic          code_err_q, code_err_d;

   logic          code_ok_s, accept_s, push_s, pop_s;
   logic          fifo_full_s, fifo_empty_s;
   logic [7:0]    fifo_rdata_s;
   logic [FAW:0]  fifo_count_s, count_nxt_s;

   assign code_ok_s = is_onehot4(key_code[ROW_MSB:ROW_LSB]) &&
                      is_onehot4(key_code[COL_MSB:COL_LSB]);
   assign accept_s  = key_valid && !fifo_full_s;
   assign push_s    = accept_s && code_ok_s;

   keypad_code_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push_s),
      .wdata (key_code),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Press/gap sequencer; the counter loads N-1 and the state moves on the edge after 0.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_row_d = cur_row_q;
      cur_col_d = cur_col_q;
      pop_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s     = 1'b1;
               cur_row_d = fifo_rdata_s[ROW_MSB:ROW_LSB];
               cur_col_d = fifo_rdata_s[COL_MSB:COL_LSB];
               cnt_d     = HOLD_LOAD;
               state_d   = S_PRESS;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_PRESS: begin
            if (cnt_q == '0) begin
               cnt_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end else if (!fifo_empty_s) begin
               pop_s     = 1'b1;
               cur_row_d = fifo_rdata_s[ROW_MSB:ROW_LSB];
               cur_col_d = fifo_rdata_s[COL_MSB:COL_LSB];
               cnt_d     = HOLD_LOAD;
               state_d   = S_PRESS;
            end else begin
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Status outputs are registered from next-state so they line up with state_q.
   always_comb begin
      count_nxt_s  = fifo_count_s + (FAW+1)'(push_s) - (FAW+1)'(pop_s);
      key_active_d = (state_d == S_PRESS);
      busy_d       = (state_d != S_IDLE) || (count_nxt_s != '0);
      code_err_d   = accept_s && !code_ok_s;
   end

   // Main state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         cur_row_q    <= 4'b0000;
         cur_col_q    <= 4'b0000;
         key_active_q <= 1'b0;
         busy_q       <= 1'b0;
         code_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_row_q    <= cur_row_d;
         cur_col_q    <= cur_col_d;
         key_active_q <= key_active_d;
         busy_q       <= busy_d;
         code_err_q   <= code_err_d;
      end
   end

   // Column answer behaves like a closed switch between the pressed row and column.
   always_comb begin
      if ((state_q == S_PRESS) && ((row & cur_row_q) != 4'b0000)) begin
         col = cur_col_q;
      end else begin
         col = 4'b0000;
      end
   end

   assign key_ready  = !fifo_full_s;
   assign key_active = key_active_q;
   assign busy       = busy_q;
   assign code_err   = code_err_q;

endmodule
